// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, next-PC selection with
// jump/branch redirect, IF/ID pipeline register with flush-to-bubble,
// and saturating stall/flush event counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWrite,
   input  logic        IFIDWrite,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic [31:0] inst_in,
   output logic [31:0] pc_out,
   output logic [31:0] inst_IFID,
   output logic [31:0] pcplus4_IFID,
   output logic        valid_IFID,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        redirect;
   logic        flush;

   // Next-PC selection; jump outranks branch, targets are word-aligned on load.
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      redirect = jump | branch_taken;
      flush    = IFIDWrite & redirect;
      next_pc  = pc_plus4;
      if (jump)
         next_pc = {jump_target[31:2], 2'b00};
      else if (branch_taken)
         next_pc = {branch_target[31:2], 2'b00};
   end

   // Program counter; a frozen PC also ignores any redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc_q <= {RESET_PC[31:2], 2'b00};
      else if (PCWrite)
         pc_q <= next_pc;
   end

   // IF/ID register; a redirect turns the fetched slot into a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_IFID    <= NOP_INST;
         pcplus4_IFID <= 32'h0000_0000;
         valid_IFID   <= 1'b0;
      end else if (IFIDWrite) begin
         pcplus4_IFID <= pc_plus4;
         if (redirect) begin
            inst_IFID  <= NOP_INST;
            valid_IFID <= 1'b0;
         end else begin
            inst_IFID  <= inst_in;
            valid_IFID <= 1'b1;
         end
      end
   end

   // Saturating event counters for stalled cycles and applied flushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'h0000;
         flush_cnt <= 16'h0000;
      end else begin
         if (!PCWrite && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (flush && flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

   assign pc_out = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, branch/jump
// flush, priority, alignment, wrap, async reset and counter saturation.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] inst_in;
   logic [31:0] pc_out;
   logic [31:0] inst_IFID;
   logic [31:0] pcplus4_IFID;
   logic        valid_IFID;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int n_chk;
   int n_err;

   fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .inst_in(inst_in),
      .pc_out(pc_out), .inst_IFID(inst_IFID), .pcplus4_IFID(pcplus4_IFID),
      .valid_IFID(valid_IFID), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory: word tagged with its own address.
   always_comb inst_in = {16'hC0DE, pc_out[15:0]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [31:0] pp4,
                           input logic vld);
      chk({tag, ".pc"}, pc_out, pc);
      chk({tag, ".inst"}, inst_IFID, inst);
      chk({tag, ".pp4"}, pcplus4_IFID, pp4);
      chk({tag, ".valid"}, {31'd0, valid_IFID}, {31'd0, vld});
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      PCWrite = 1'b1;
      IFIDWrite = 1'b1;
      branch_taken = 1'b0;
      branch_target = 32'h0;
      jump = 1'b0;
      jump_target = 32'h0;
      #2;
      chk_ifid("reset", 32'h0, NOP, 32'h0, 1'b0);
      chk("reset.stall", {16'd0, stall_cnt}, 32'd0);
      chk("reset.flush", {16'd0, flush_cnt}, 32'd0);

      @(negedge clk);
      rst = 1'b0;

      // Sequential fetch
      step(); chk_ifid("seq1", 32'h4, 32'hC0DE0000, 32'h4, 1'b1);
      step(); chk_ifid("seq2", 32'h8, 32'hC0DE0004, 32'h8, 1'b1);

      // Load-use stall for two cycles at pc 8
      PCWrite = 1'b0; IFIDWrite = 1'b0;
      step(); step();
      chk_ifid("stall", 32'h8, 32'hC0DE0004, 32'h8, 1'b1);
      chk("stall.cnt", {16'd0, stall_cnt}, 32'd2);
      PCWrite = 1'b1; IFIDWrite = 1'b1;
      step(); chk_ifid("resume", 32'hC, 32'hC0DE0008, 32'hC, 1'b1);
      step(); chk_ifid("seq4", 32'h10, 32'hC0DE000C, 32'h10, 1'b1);

      // Taken branch at pc 16
      branch_taken = 1'b1; branch_target = 32'h40;
      step(); chk_ifid("br", 32'h40, NOP, 32'h14, 1'b0);
      chk("br.flush", {16'd0, flush_cnt}, 32'd1);
      branch_taken = 1'b0;
      step(); chk_ifid("br_after", 32'h44, 32'hC0DE0040, 32'h44, 1'b1);

      // Jump beats branch
      jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h40;
      step(); chk_ifid("jmp_pri", 32'h100, NOP, 32'h48, 1'b0);
      chk("jmp_pri.flush", {16'd0, flush_cnt}, 32'd2);
      // Misaligned jump target
      branch_taken = 1'b0; jump_target = 32'h103;
      step(); chk_ifid("jmp_align", 32'h100, NOP, 32'h104, 1'b0);
      chk("jmp_align.flush", {16'd0, flush_cnt}, 32'd3);

      // Stall beats redirect
      jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
      PCWrite = 1'b0; IFIDWrite = 1'b0;
      step(); chk_ifid("stall_br", 32'h100, NOP, 32'h104, 1'b0);
      chk("stall_br.flush", {16'd0, flush_cnt}, 32'd3);
      chk("stall_br.stall", {16'd0, stall_cnt}, 32'd3);

      // PC advances while IF/ID holds
      branch_taken = 1'b0; PCWrite = 1'b1;
      step(); chk_ifid("indep", 32'h104, NOP, 32'h104, 1'b0);

      // Wrap from the top of the address space
      IFIDWrite = 1'b1; jump = 1'b1; jump_target = 32'hFFFF_FFFC;
      step(); chk_ifid("to_top", 32'hFFFF_FFFC, NOP, 32'h108, 1'b0);
      chk("to_top.flush", {16'd0, flush_cnt}, 32'd4);
      jump = 1'b0;
      step(); chk_ifid("wrap", 32'h0, 32'hC0DEFFFC, 32'h0, 1'b1);

      // Advance to pc 0x20, then assert reset between edges
      repeat (8) step();
      chk("pre_rst.pc", pc_out, 32'h20);
      branch_taken = 1'b1; branch_target = 32'h80;
      #2 rst = 1'b1;
      #1;
      chk_ifid("async_rst", RST_PC, NOP, 32'h0, 1'b0);
      chk("async_rst.stall", {16'd0, stall_cnt}, 32'd0);
      chk("async_rst.flush", {16'd0, flush_cnt}, 32'd0);
      step(); chk("rst_hold.pc", pc_out, RST_PC);
      branch_taken = 1'b0;
      rst = 1'b0;
      step(); chk_ifid("post_rst", 32'h4, 32'hC0DE0000, 32'h4, 1'b1);

      // Stall counter saturation
      PCWrite = 1'b0;
      repeat (65535) @(posedge clk);
      #1;
      chk("sat.stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
      step(); step(); step();
      chk("sat_hold.stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
      chk("sat.pc", pc_out, 32'h4);
      chk("sat.flush", {16'd0, flush_cnt}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000, instruction word inserted into IF/ID on flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 PCWrite  input  1  PC load enable from hazard unit; 0 = freeze PC.
REQ-006 IFIDWrite  input  1  IF/ID load enable from hazard unit; 0 = hold IF/ID.
REQ-007 branch_taken  input  1  resolved taken beq/bne from ID stage.
REQ-008 branch_target  input  32  branch destination address.
REQ-009 jump  input  1  j/jal decoded in ID stage.
REQ-010 jump_target  input  32  jump destination address.
REQ-011 inst_in  input  32  instruction memory read data for address pc_out (combinational memory).
REQ-012 pc_out  output  32  current PC, drives instruction memory address.
REQ-013 inst_IFID  output  32  registered instruction to ID stage.
REQ-014 pcplus4_IFID  output  32  registered PC+4 of that instruction.
REQ-015 valid_IFID  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-016 stall_cnt  output  16  count of cycles with PCWrite=0.
REQ-017 flush_cnt  output  16  count of applied flushes.

Function
REQ-018 pc_plus4 SHALL be pc_out + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-019 redirect SHALL be (jump | branch_taken); next_pc priority: jump -> jump_target, else branch_taken -> branch_target, else pc_plus4.
REQ-020 Target bits [1:0] SHALL be forced to 0 when loaded; pc_out[1:0] is always 0.
REQ-021 When PCWrite=1, PC SHALL load next_pc at the clock edge; when PCWrite=0, PC holds and redirect is ignored for the PC.
REQ-022 IF/ID SHALL hold (all three fields unchanged) when IFIDWrite=0, regardless of redirect.
REQ-023 When IFIDWrite=1 and redirect=1, IF/ID SHALL load inst_IFID=NOP_INST, pcplus4_IFID=pc_plus4, valid_IFID=0 (flush).
REQ-024 When IFIDWrite=1 and redirect=0, IF/ID SHALL load inst_in, pc_plus4, valid_IFID=1.
REQ-025 PC and IF/ID enables SHALL act independently; PCWrite=1 with IFIDWrite=0 advances PC while IF/ID holds.
REQ-026 Fetch-to-ID latency SHALL be one cycle; taken branch/jump costs exactly one bubble.
REQ-027 stall_cnt SHALL increment by 1 on each edge where PCWrite=0, saturating at 16'hFFFF.
REQ-028 flush_cnt SHALL increment by 1 on each edge where a flush per REQ-023 is applied, saturating at 16'hFFFF.
REQ-029 All outputs SHALL be registered or derived only from registers (no input-to-output combinational path except none).

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, set pc_out=RESET_PC, inst_IFID=NOP_INST, pcplus4_IFID=0, valid_IFID=0, stall_cnt=0, flush_cnt=0.
REQ-031 While rst=1 all state SHALL hold reset values; assertion mid-stall or mid-flush discards pending redirect.
REQ-032 First edge after rst deassert SHALL fetch from RESET_PC under normal enable rules.

Verification
REQ-033 Sequential fetch: reset, PCWrite=IFIDWrite=1, inst_in=PC-derived -> pc_out 0,4,8,12; IF/ID gets inst at PC n-4, pcplus4_IFID=n, valid=1.
REQ-034 Load-use stall: PCWrite=IFIDWrite=0 for 2 cycles at pc_out=8 -> pc_out stays 8, IF/ID unchanged, stall_cnt=2, then resumes to 12.
REQ-035 Taken branch: pc_out=16, branch_taken=1, branch_target=32'h40 -> next pc_out=32'h40, inst_IFID=NOP_INST, valid=0, flush_cnt=1; next cycle valid=1.
REQ-036 Jump vs branch same cycle: jump=1 target 32'h100, branch_taken=1 target 32'h40 -> pc_out=32'h100; misaligned target 32'h103 -> pc_out=32'h100.
REQ-037 Stall beats redirect: PCWrite=IFIDWrite=0, branch_taken=1 -> PC and IF/ID hold, flush_cnt unchanged; wrap: pc_out=32'hFFFF_FFFC -> 0.
REQ-038 Async reset mid-run: assert rst between edges at pc_out=32'h20 -> pc_out=RESET_PC and counters 0 before next edge; saturation: stall_cnt preset path to 16'hFFFF stays 16'hFFFF.
